// File: rtl/reg_scoreboard_if.sv
// ID/WB-side bus of the pending-write register scoreboard.
// The master drives the ID and WB request fields; the slave returns stall/issue and status.
interface reg_scoreboard_if #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned STAT_W = 16
);
  localparam int unsigned IDX_W = $clog2(NREGS);

  logic              id_valid;
  logic [IDX_W-1:0]  id_rs;
  logic [IDX_W-1:0]  id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [IDX_W-1:0]  id_dst;
  logic              id_reg_write;
  logic              wb_reg_write;
  logic [IDX_W-1:0]  wb_dst;
  logic              stall;
  logic              issue;
  logic [NREGS-1:0]  pending_vec;
  logic [STAT_W-1:0] stall_cnt;
  logic              err;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_write,
    output wb_reg_write, wb_dst,
    input  stall, issue, pending_vec, stall_cnt, err
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst, id_reg_write,
    input  wb_reg_write, wb_dst,
    output stall, issue, pending_vec, stall_cnt, err
  );
endinterface

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters beside ID; stalls issue on RAW hazards the
// WB->ID forward cannot cover, or when a destination counter is full.
module reg_scoreboard #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned STAT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  reg_scoreboard_if.slave  sb
);
  localparam int unsigned IDX_W = $clog2(NREGS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]  cnt_q [NREGS];
  logic [CNT_W-1:0]  cnt_d [NREGS];
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic              err_q, err_d;

  logic [NREGS-1:0]  ret, inc, pend;
  logic              haz_rs, haz_rt, full, stall_c, issue_c;

  // Still pending after this cycle's retire; a lone retiring write is forwarded.
  function automatic logic busy(input logic [CNT_W-1:0] c, input logic r);
    return (c > CNT_W'(1)) || ((c == CNT_W'(1)) && !r);
  endfunction

  always_comb begin
    ret  = '0;
    pend = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      ret[r]  = sb.wb_reg_write && (sb.wb_dst == IDX_W'(r));
      pend[r] = (cnt_q[r] != '0);
    end
  end

  always_comb begin
    haz_rs  = sb.id_use_rs && (sb.id_rs != '0) && busy(cnt_q[sb.id_rs], ret[sb.id_rs]);
    haz_rt  = sb.id_use_rt && (sb.id_rt != '0) && busy(cnt_q[sb.id_rt], ret[sb.id_rt]);
    full    = sb.id_reg_write && (sb.id_dst != '0) &&
              (cnt_q[sb.id_dst] == CNT_MAX) && !ret[sb.id_dst];
    stall_c = sb.id_valid && (haz_rs || haz_rt || full);
    issue_c = sb.id_valid && !stall_c;
  end

  always_comb begin
    inc = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      inc[r] = issue_c && sb.id_reg_write && (sb.id_dst == IDX_W'(r));
    end
  end

  always_comb begin
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    for (int unsigned r = 0; r < NREGS; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    cnt_d[0] = '0;
    for (int unsigned r = 1; r < NREGS; r++) begin
      if (ret[r] && (cnt_q[r] == '0)) begin
        err_d = 1'b1;
      end
      if (inc[r] && !ret[r]) begin
        cnt_d[r] = cnt_q[r] + CNT_W'(1);
      end else if (ret[r] && !inc[r] && (cnt_q[r] != '0)) begin
        cnt_d[r] = cnt_q[r] - CNT_W'(1);
      end
    end
    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        cnt_q[r] <= '0;
      end
      stall_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign sb.stall       = stall_c;
  assign sb.issue       = issue_c;
  assign sb.pending_vec = pend;
  assign sb.stall_cnt   = stall_cnt_q;
  assign sb.err         = err_q;
endmodule
